ram_arb: RTL and testbench



---
 rtl/ram_arb.sv | 166 ++++++++++++++++
 tb/tb_ram_arb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arb.sv
// ram_arb -- round-robin arbiter sharing port A of ram_dp among NUM_REQ requesters.
//
// Issues at most one RAM read or write per cycle. Each read result is routed
// back to the requester that issued it, one cycle later. A requester may lock
// the port for up to MAX_BURST back-to-back beats.
//
// Ports:
//   clock, reset   single rising-edge clock, synchronous active-high reset
//   req_valid      per-requester request pending
//   req_ready      per-requester grant (one-hot or zero, combinational)
//   req_wen        per-requester 1 = write, 0 = read
//   req_lock       per-requester "keep ownership after this beat"
//   req_addr       packed per-requester address slices
//   req_wdata      packed per-requester write-data slices
//   rsp_valid      registered one-hot read-data strobe
//   rsp_data       read data (passthrough of ram_dout)
//   ram_cen/wen/addr/din   RAM port-A drive, combinational from the grant
//   ram_dout       RAM port-A read data (registered inside the RAM)
module ram_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_wen,
    input  logic [NUM_REQ-1:0]              req_lock,
    input  logic [NUM_REQ*$clog2(DEPTH)-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            ram_cen,
    output logic                            ram_wen,
    output logic [$clog2(DEPTH)-1:0]        ram_addr,
    output logic [DATA_WIDTH-1:0]           ram_din,
    input  logic [DATA_WIDTH-1:0]           ram_dout
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int IDX_W      = $clog2(NUM_REQ);
    localparam int CNT_W      = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

    // Requester index after i, wrapping modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? {IDX_W{1'b0}} : i + IDX_W'(1);
    endfunction

    logic [0:0]            state_r;
    logic [IDX_W-1:0]      ptr_r;
    logic [IDX_W-1:0]      owner_r;
    logic [CNT_W-1:0]      beat_cnt_r;
    logic [NUM_REQ-1:0]    rsp_valid_r;

    logic                  owner_hold_s;
    logic [IDX_W-1:0]      scan_start_s;
    int                    scan_pos_s;
    logic [IDX_W-1:0]      scan_idx_s;
    logic                  rr_hit_s;
    logic                  rr_found_s;
    logic [IDX_W-1:0]      rr_idx_s;
    logic                  grant_any_s;
    logic [IDX_W-1:0]      grant_idx_s;
    logic                  beat_s;
    logic [CNT_W-1:0]      beat_cnt_inc_s;

    // A locked owner keeps the port only while it is still requesting; once it
    // drops valid, round-robin restarts just past it in the same cycle.
    assign owner_hold_s = (state_r == ST_LOCKED) && req_valid[owner_r];
    assign scan_start_s = (state_r == ST_LOCKED) ? next_idx(owner_r) : ptr_r;

    // Round-robin scan: first valid requester starting at scan_start_s.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = {IDX_W{1'b0}};
        scan_pos_s = 0;
        scan_idx_s = {IDX_W{1'b0}};
        rr_hit_s   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_pos_s = (int'(scan_start_s) + k) % NUM_REQ;
            scan_idx_s = IDX_W'(scan_pos_s);
            rr_hit_s   = !rr_found_s && req_valid[scan_idx_s];
            rr_idx_s   = rr_hit_s ? scan_idx_s : rr_idx_s;
            rr_found_s = rr_found_s | rr_hit_s;
        end
    end

    // Final grant selection: locked owner wins, otherwise the round-robin pick.
    always_comb begin
        if (owner_hold_s) begin
            grant_any_s = 1'b1;
            grant_idx_s = owner_r;
        end else begin
            grant_any_s = rr_found_s;
            grant_idx_s = rr_idx_s;
        end
    end

    assign req_ready = grant_any_s ? (NUM_REQ'(1) << grant_idx_s) : {NUM_REQ{1'b0}};
    assign beat_s    = |(req_valid & req_ready);
    assign ram_cen   = beat_s;

    // RAM payload mux from the granted slice; zero when idle.
    always_comb begin
        if (beat_s) begin
            ram_wen  = req_wen[grant_idx_s];
            ram_addr = req_addr[int'(grant_idx_s) * ADDR_WIDTH +: ADDR_WIDTH];
            ram_din  = req_wdata[int'(grant_idx_s) * DATA_WIDTH +: DATA_WIDTH];
        end else begin
            ram_wen  = 1'b0;
            ram_addr = {ADDR_WIDTH{1'b0}};
            ram_din  = {DATA_WIDTH{1'b0}};
        end
    end

    assign beat_cnt_inc_s = beat_cnt_r + CNT_W'(1);

    // Arbitration state, burst tracking and read-response strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_ARB;
            ptr_r       <= {IDX_W{1'b0}};
            owner_r     <= {IDX_W{1'b0}};
            beat_cnt_r  <= {CNT_W{1'b0}};
            rsp_valid_r <= {NUM_REQ{1'b0}};
        end else begin
            rsp_valid_r <= (beat_s && !req_wen[grant_idx_s]) ? req_ready : {NUM_REQ{1'b0}};
            if (beat_s) begin
                // Priority moves past whoever just transferred, so a finished
                // burst resumes round-robin from owner+1.
                ptr_r <= next_idx(grant_idx_s);
                if (owner_hold_s) begin
                    if (!req_lock[owner_r] || (beat_cnt_inc_s == BURST_LAST)) begin
                        state_r    <= ST_ARB;
                        beat_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        state_r    <= ST_LOCKED;
                        beat_cnt_r <= beat_cnt_inc_s;
                    end
                end else if (req_lock[grant_idx_s] && (MAX_BURST > 1)) begin
                    state_r    <= ST_LOCKED;
                    owner_r    <= grant_idx_s;
                    beat_cnt_r <= CNT_W'(1);
                end else begin
                    state_r    <= ST_ARB;
                    beat_cnt_r <= {CNT_W{1'b0}};
                end
            end else begin
                state_r    <= ST_ARB;
                beat_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = ram_dout;

endmodule

// File: tb/tb_ram_arb.sv
module tb_ram_arb;

    logic         clock;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [3:0]   req_wen;
    logic [3:0]   req_lock;
    logic [15:0]  req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic         ram_cen;
    logic         ram_wen;
    logic [3:0]   ram_addr;
    logic [31:0]  ram_din;
    logic [31:0]  ram_dout;

    ram_arb #(.NUM_REQ(4), .DATA_WIDTH(32), .DEPTH(16), .MAX_BURST(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .ram_cen   (ram_cen),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  oh;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic        mon_en = 1'b0;
    logic [3:0]  addr_a [4];
    logic [31:0] wdata_a [4];
    logic [31:0] ref_mem [16];
    logic [31:0] mem [16];

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural RAM port A: registered read, preloaded while reset is high.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA500_0000 + i;
        end else if (ram_cen) begin
            if (ram_wen) mem[ram_addr] <= ram_din;
            else         ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every response strobe must match the head of the scoreboard.
    always @(negedge clock) begin
        if (mon_en && rsp_valid !== 4'b0000) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: got rsp_valid %b expected none", rsp_valid);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rsp_onehot", {28'd0, rsp_valid}, {28'd0, e.oh});
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    // One cycle: drive inputs, check grant and RAM drive, record expected read.
    task automatic step(input logic [3:0] v, input logic [3:0] w, input logic [3:0] l,
                        input logic [3:0] exp, input logic rst, input string nm);
        int g;
        reset     = rst;
        req_valid = v;
        req_wen   = w;
        req_lock  = l;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*4 +: 4]    = addr_a[i];
            req_wdata[i*32 +: 32] = wdata_a[i];
        end
        #2;
        chk({nm, "_ready"}, {28'd0, req_ready}, {28'd0, exp});
        chk({nm, "_cen"}, {31'd0, ram_cen}, {31'd0, (exp != 4'b0000)});
        if (exp != 4'b0000) begin
            g = 0;
            for (int i = 0; i < 4; i++) if (exp[i]) g = i;
            chk({nm, "_addr"}, {28'd0, ram_addr}, {28'd0, addr_a[g]});
            chk({nm, "_wen"}, {31'd0, ram_wen}, {31'd0, w[g]});
            if (w[g]) begin
                chk({nm, "_din"}, ram_din, wdata_a[g]);
                ref_mem[addr_a[g]] = wdata_a[g];
            end else if (!rst) begin
                sb_q.push_back('{oh: exp, data: ref_mem[addr_a[g]], cyc: cyc + 1});
            end
        end else begin
            chk({nm, "_idle_drive"}, {27'd0, ram_wen, ram_addr}, 32'd0);
            chk({nm, "_idle_din"}, ram_din, 32'd0);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA500_0000 + i;
        for (int i = 0; i < 4; i++) begin
            addr_a[i]  = 4'd0;
            wdata_a[i] = 32'd0;
        end
        reset = 1'b1; req_valid = 4'b0; req_wen = 4'b0; req_lock = 4'b0;
        req_addr = 16'd0; req_wdata = 128'd0;
        @(posedge clock);
        #1;
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, "rst0");
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, "rst1");
        chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        mon_en = 1'b1;
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "post_rst_idle");

        // All four reading, no lock: grants rotate 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) addr_a[i] = 4'((k * 2 + i) % 16);
            step(4'b1111, 4'b0000, 4'b0000, 4'(1 << (k % 4)), 1'b0, "rr");
        end

        // Requester 2 writes 0xDEADBEEF to 5, requester 0 reads it back.
        addr_a[2] = 4'd5; wdata_a[2] = 32'hDEAD_BEEF;
        step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, "wr5");
        addr_a[0] = 4'd5;
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, "rd5");

        // Requester 1 locks with 0 and 3 also valid: 1,1,1,1 then 3 then 0.
        addr_a[0] = 4'd7; addr_a[1] = 4'd9; addr_a[3] = 4'd11;
        for (int k = 0; k < 4; k++)
            step(4'b1011, 4'b0000, 4'b0010, 4'b0010, 1'b0, "burst");
        step(4'b1011, 4'b0000, 4'b0010, 4'b1000, 1'b0, "after_burst3");
        step(4'b1011, 4'b0000, 4'b0010, 4'b0001, 1'b0, "after_burst0");
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "gap0");

        // Requester 1 locks, drops valid after 2 beats: 2 granted same cycle.
        addr_a[2] = 4'd12;
        step(4'b0110, 4'b0000, 4'b0010, 4'b0010, 1'b0, "lk_a");
        step(4'b0110, 4'b0000, 4'b0010, 4'b0010, 1'b0, "lk_b");
        step(4'b0100, 4'b0000, 4'b0010, 4'b0100, 1'b0, "drop_to2");
        // Back in ARB with ptr=3: scan 3,0 gives requester 0.
        step(4'b0101, 4'b0000, 4'b0000, 4'b0001, 1'b0, "arb_again");

        // Reset during the third beat of a locked read burst.
        addr_a[1] = 4'd3; addr_a[0] = 4'd2;
        step(4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b0, "rb1");
        step(4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b0, "rb2");
        step(4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b1, "rb3_reset");
        chk("midburst_rsp_cleared", {28'd0, rsp_valid}, 32'd0);
        step(4'b0101, 4'b0000, 4'b0000, 4'b0001, 1'b0, "first_after_reset");
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "drain");

        // Five idle cycles: nothing granted, nothing returned.
        for (int k = 0; k < 5; k++) begin
            chk("idle_rsp_valid", {28'd0, rsp_valid}, 32'd0);
            step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "idle");
        end

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
